// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory burst loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int         BURSTCOUNT_W = 12;
  localparam logic [3:0] IMEM_BE_ALL  = 4'hF;

endpackage

// File: rtl/imem_burst_loader.sv
// Avalon-MM burst-read master that copies a program image into imem while
// holding the core in reset. One burst outstanding at a time.
module imem_burst_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 12,
  parameter int MAX_BURST       = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [31:0]                src_addr,
  input  logic [IMEM_ADDR_WIDTH:0]   num_words,
  output logic                       busy,
  output logic                       done,
  output logic                       core_hold,
  input  logic                       avm_rx_waitrequest,
  output logic [BURSTCOUNT_W-1:0]    avm_rx_burstcount,
  output logic [31:0]                avm_rx_address,
  output logic                       avm_rx_read,
  input  logic [31:0]                avm_rx_readdata,
  input  logic                       avm_rx_readdatavalid,
  output logic                       imem_write,
  output logic [31:0]                imem_waddr,
  output logic [31:0]                imem_wdata,
  output logic [3:0]                 imem_be
);

  localparam int            RW    = IMEM_ADDR_WIDTH + 1;
  localparam logic [RW-1:0] DEPTH = RW'(1) << IMEM_ADDR_WIDTH;

  state_e                       state_q, state_d;
  logic [31:0]                  rd_addr_q, rd_addr_d;
  logic [RW-1:0]                remaining_q, remaining_d;
  logic [BURSTCOUNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [IMEM_ADDR_WIDTH-1:0]   wr_idx_q, wr_idx_d;
  logic                         wr_q, wr_d;
  logic [31:0]                  waddr_q, waddr_d;
  logic [31:0]                  wdata_q, wdata_d;

  logic [RW-1:0]                blen;
  logic [RW-1:0]                nw_clamped;

  // Clamping to the imem depth is what keeps wr_idx from ever wrapping.
  assign nw_clamped = (num_words > DEPTH) ? DEPTH : num_words;
  assign blen       = (32'(remaining_q) < 32'(MAX_BURST)) ? remaining_q : RW'(MAX_BURST);

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    wr_idx_d    = wr_idx_q;
    wr_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_addr_d   = src_addr & ~32'd3;
          wr_idx_d    = '0;
          remaining_d = nw_clamped;
          state_d     = (nw_clamped == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (!avm_rx_waitrequest) begin
          rd_addr_d   = rd_addr_q + (32'(blen) << 2);
          remaining_d = remaining_q - blen;
          beat_cnt_d  = BURSTCOUNT_W'(blen);
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (avm_rx_readdatavalid) begin
          wr_d       = 1'b1;
          waddr_d    = 32'({wr_idx_q, 2'b00});
          wdata_d    = avm_rx_readdata;
          wr_idx_d   = wr_idx_q + IMEM_ADDR_WIDTH'(1);
          beat_cnt_d = beat_cnt_q - BURSTCOUNT_W'(1);
          if (beat_cnt_q == BURSTCOUNT_W'(1)) begin
            state_d = (remaining_q == '0) ? ST_DONE : ST_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      wr_idx_q    <= '0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_idx_q    <= wr_idx_d;
      wr_q        <= wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Request fields are only driven while a request is being presented.
  assign busy              = (state_q != ST_IDLE);
  assign core_hold         = busy;
  assign done              = (state_q == ST_DONE);
  assign avm_rx_read       = (state_q == ST_REQ);
  assign avm_rx_burstcount = avm_rx_read ? BURSTCOUNT_W'(blen) : '0;
  assign avm_rx_address    = avm_rx_read ? rd_addr_q : '0;
  assign imem_write        = wr_q;
  assign imem_waddr        = waddr_q;
  assign imem_wdata        = wdata_q;
  assign imem_be           = IMEM_BE_ALL;

endmodule

// File: tb/tb_imem_burst_loader.sv
// Directed bench for imem_burst_loader: an Avalon slave plus a transaction-level
// model of expected bursts, imem writes and status, checked every cycle.
module tb_imem_burst_loader;

  localparam int AW = 12;
  localparam int MB = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [AW:0] num_words = '0;
  logic        busy, done, core_hold;
  logic        avm_rx_waitrequest = 1'b0;
  logic [11:0] avm_rx_burstcount;
  logic [31:0] avm_rx_address;
  logic        avm_rx_read;
  logic [31:0] avm_rx_readdata = '0;
  logic        avm_rx_readdatavalid = 1'b0;
  logic        imem_write;
  logic [31:0] imem_waddr, imem_wdata;
  logic [3:0]  imem_be;

  imem_burst_loader #(.IMEM_ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .num_words(num_words), .busy(busy), .done(done), .core_hold(core_hold),
    .avm_rx_waitrequest(avm_rx_waitrequest), .avm_rx_burstcount(avm_rx_burstcount),
    .avm_rx_address(avm_rx_address), .avm_rx_read(avm_rx_read),
    .avm_rx_readdata(avm_rx_readdata), .avm_rx_readdatavalid(avm_rx_readdatavalid),
    .imem_write(imem_write), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .imem_be(imem_be)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state: expectations for the cycle observed at the next negedge
  bit          e_busy, e_done, e_read, e_wr;
  logic [31:0] e_waddr, e_wdata;
  logic [31:0] m_src, m_addr, s_addr;
  int          m_rem, m_widx, beats_left, stall_cnt;
  int          wait_cfg;
  bit          gaps, spurious;
  int          cnt_wr, cnt_done, cnt_burst;
  logic [31:0] b_addr[$];
  int          b_len[$];

  function automatic logic [31:0] pat(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_rst();
    chk("rst_busy", busy, 0);            chk("rst_done", done, 0);
    chk("rst_hold", core_hold, 0);       chk("rst_read", avm_rx_read, 0);
    chk("rst_write", imem_write, 0);     chk("rst_bcnt", avm_rx_burstcount, 0);
    chk("rst_addr", avm_rx_address, 0);  chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);     chk("rst_be", imem_be, 4'hF);
  endtask

  task automatic model_clear();
    e_busy = 0; e_done = 0; e_read = 0; e_wr = 0;
    m_rem = 0; m_widx = 0; beats_left = 0; stall_cnt = 0;
  endtask

  // One cycle: check outputs, then drive inputs for the next posedge and
  // derive what the outputs must be one cycle later.
  task automatic step(bit st, logic [31:0] sa, int nw);
    int blen;
    bit n_done, n_wr, n_read, n_busy, acc, legit;
    @(negedge clk);
    blen = (m_rem < MB) ? m_rem : MB;
    chk("busy", busy, e_busy);
    chk("core_hold", core_hold, e_busy);
    chk("done", done, e_done);
    chk("read", avm_rx_read, e_read);
    chk("be", imem_be, 4'hF);
    chk("write", imem_write, e_wr);
    if (e_read) begin
      chk("address", avm_rx_address, m_addr);
      chk("burstcount", avm_rx_burstcount, blen);
    end
    if (e_wr) begin
      chk("waddr", imem_waddr, e_waddr);
      chk("wdata", imem_wdata, e_wdata);
    end
    if (imem_write) cnt_wr++;
    if (done) cnt_done++;

    start     = st;
    src_addr  = sa;
    num_words = (AW+1)'(nw);
    avm_rx_waitrequest = e_read && (stall_cnt < wait_cfg);
    if (avm_rx_waitrequest) stall_cnt++;
    acc = e_read && !avm_rx_waitrequest;
    if (avm_rx_read && !avm_rx_waitrequest) begin
      cnt_burst++;
      b_addr.push_back(avm_rx_address);
      b_len.push_back(int'(avm_rx_burstcount));
    end
    legit = 0;
    if (beats_left > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
      avm_rx_readdatavalid = 1'b1;
      avm_rx_readdata      = pat(s_addr);
      s_addr               = s_addr + 32'd4;
      legit                = 1;
    end else if (spurious && beats_left == 0) begin
      avm_rx_readdatavalid = 1'b1;
      avm_rx_readdata      = 32'hBAD0_BAD0;
    end else begin
      avm_rx_readdatavalid = 1'b0;
    end

    n_busy = e_busy; n_read = e_read; n_done = 0; n_wr = 0;
    if (e_done) n_busy = 0;
    if (st && !e_busy) begin
      m_src  = sa & ~32'd3;
      m_addr = m_src;
      m_widx = 0;
      m_rem  = (nw > (1 << AW)) ? (1 << AW) : nw;
      n_busy = 1;
      stall_cnt = 0;
      if (m_rem == 0) n_done = 1;
      else n_read = 1;
    end
    if (acc) begin
      beats_left = blen;
      s_addr     = m_addr;
      m_addr     = m_addr + 32'(4 * blen);
      m_rem      = m_rem - blen;
      n_read     = 0;
    end
    if (legit) begin
      n_wr    = 1;
      e_waddr = 32'(4 * m_widx);
      e_wdata = pat(m_src + 32'(4 * m_widx));
      m_widx++;
      beats_left--;
      if (beats_left == 0) begin
        if (m_rem == 0) n_done = 1;
        else begin n_read = 1; stall_cnt = 0; end
      end
    end
    e_busy = n_busy; e_read = n_read; e_done = n_done; e_wr = n_wr;
  endtask

  task automatic run_load(logic [31:0] src, int n, int wcfg, bit g, int poke_at, int stop_at);
    bit fin;
    cnt_wr = 0; cnt_done = 0; cnt_burst = 0;
    b_addr.delete(); b_len.delete();
    wait_cfg = wcfg; gaps = g; fin = 0;
    step(1, src, n);
    for (int i = 0; i < 20000 && !fin; i++) begin
      if (i == poke_at) step(1, 32'hDEAD_0000, 3);
      else step(0, src, n);
      if (i == stop_at) return;
      if (!e_busy) fin = 1;
    end
    if (!fin) chk("timeout", 0, 1);
    step(0, src, n);
  endtask

  initial begin
    model_clear();
    wait_cfg = 0; gaps = 0; spurious = 0; s_addr = '0; m_src = '0; m_addr = '0;
    #2 check_rst();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // small single burst
    run_load(32'h1000, 5, 0, 0, -1, -1);
    chk("t1_bursts", cnt_burst, 1);
    chk("t1_baddr", b_addr[0], 32'h1000);
    chk("t1_blen", b_len[0], 5);
    chk("t1_writes", cnt_wr, 5);
    chk("t1_dones", cnt_done, 1);

    // multi-burst split 64/64/2
    run_load(32'h0, 130, 0, 0, -1, -1);
    chk("t2_bursts", cnt_burst, 3);
    chk("t2_blen0", b_len[0], 64);
    chk("t2_blen1", b_len[1], 64);
    chk("t2_blen2", b_len[2], 2);
    chk("t2_baddr1", b_addr[1], 32'h100);
    chk("t2_baddr2", b_addr[2], 32'h200);
    chk("t2_writes", cnt_wr, 130);
    chk("t2_dones", cnt_done, 1);

    // 3-cycle waitrequest stall and random valid gaps
    run_load(32'h2000, 5, 3, 1, -1, -1);
    chk("t3_bursts", cnt_burst, 1);
    chk("t3_writes", cnt_wr, 5);

    // zero-length load
    run_load(32'h3000, 0, 0, 0, -1, -1);
    chk("t4_bursts", cnt_burst, 0);
    chk("t4_writes", cnt_wr, 0);
    chk("t4_dones", cnt_done, 1);

    // clamp to imem depth
    run_load(32'h0, 5000, 0, 0, -1, -1);
    chk("t5_writes", cnt_wr, 4096);
    chk("t5_bursts", cnt_burst, 64);
    chk("t5_dones", cnt_done, 1);

    // start pulsed during DATA is ignored
    run_load(32'h3000, 10, 0, 0, 4, -1);
    chk("t6_writes", cnt_wr, 10);
    chk("t6_bursts", cnt_burst, 1);

    // source address wraps past 2^32, low address bits ignored
    run_load(32'hFFFF_FF82, 70, 0, 0, -1, -1);
    chk("t7_baddr0", b_addr[0], 32'hFFFF_FF80);
    chk("t7_baddr1", b_addr[1], 32'h0000_0080);
    chk("t7_blen1", b_len[1], 6);
    chk("t7_writes", cnt_wr, 70);

    // asynchronous reset mid-burst
    run_load(32'h4000, 40, 0, 0, -1, 10);
    #2 reset_n = 1'b0;
    #1 check_rst();
    model_clear();
    start = 0; avm_rx_readdatavalid = 0; avm_rx_waitrequest = 0;
    @(negedge clk);
    reset_n = 1'b1;
    spurious = 1;
    cnt_wr = 0;
    repeat (4) step(0, 32'h0, 0);
    spurious = 0;
    chk("t8_spurious_writes", cnt_wr, 0);
    run_load(32'h5000, 7, 1, 0, -1, -1);
    chk("t8_baddr", b_addr[0], 32'h5000);
    chk("t8_writes", cnt_wr, 7);
    chk("t8_dones", cnt_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
